cc_unit: RTL

CC_UNIT -- requirements
Module: cc_unit

---
 rtl/cc_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/cc_unit.sv
// rtl/cc_unit.sv - execute-stage ALU with registered result and condition codes
//
// Computes valB op valA for ADD/SUB/AND/XOR and derives the flags. On an
// accepted operation it registers the result. When set_cc is high it also
// registers the flags into CC, which drives the branch/cmov condition evaluator.
//
// Ports:
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous active-low reset
//   in_valid   input   1      an operation is presented this cycle
//   alu_fun    input   4      0=ADD 1=SUB 2=AND 3=XOR, any other code = ADD
//   valA       input   WIDTH  operand A
//   valB       input   WIDTH  operand B
//   set_cc     input   1      operation updates the condition codes
//   stall      input   1      hold all state this cycle
//   flush      input   1      squash the presented operation, clear out_valid
//   valE       output  WIDTH  registered result
//   out_valid  output  1      valE holds a result accepted on the last edge
//   CC         output  4      registered flags {BF, OF, SF, ZF}
//   cc_next    output  4      combinational flags of the current operands

module cc_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic             set_cc,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] valE,
  output logic             out_valid,
  output logic [3:0]       CC,
  output logic [3:0]       cc_next
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // ZF=1 out of reset so a condition evaluated before any compare sees "equal".
  localparam logic [3:0] CC_RESET = 4'b0001;

  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   sum_w;
  logic             of_flag;
  logic             bf_flag;
  logic             accept;

  always_comb begin
    result  = '0;
    sum_w   = '0;
    of_flag = 1'b0;
    bf_flag = 1'b0;
    case (alu_fun)
      ALU_SUB: begin
        result  = valB - valA;
        // Overflow only when the operand signs differ and the result
        // sign moved away from the minuend's sign.
        of_flag = (valB[MSB] ^ valA[MSB]) & (result[MSB] ^ valB[MSB]);
        bf_flag = (valB < valA);
      end
      ALU_AND: begin
        result = valB & valA;
      end
      ALU_XOR: begin
        result = valB ^ valA;
      end
      default: begin
        // ADD, and every unassigned code falls back to ADD.
        sum_w   = {1'b0, valB} + {1'b0, valA};
        result  = sum_w[MSB:0];
        of_flag = ~(valB[MSB] ^ valA[MSB]) & (result[MSB] ^ valB[MSB]);
        bf_flag = sum_w[WIDTH];
      end
    endcase
  end

  assign cc_next = {bf_flag, of_flag, result[MSB], (result == '0)};

  assign accept = in_valid & ~stall & ~flush;

  // Priority: flush beats stall, and stall beats in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valE      <= '0;
      out_valid <= 1'b0;
      CC        <= CC_RESET;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= accept;
      if (accept) begin
        valE <= result;
        if (set_cc) begin
          CC <= cc_next;
        end
      end
    end
  end

endmodule
